md_unit: RTL

Parametrised multi-cycle multiply/divide unit with HI/LO registers, placed in the E stage beside the ALU. It accepts one operation per start pulse, holds `busy` for a configurable number of cycles, and commits results to HI/LO atomically. The stall controller uses `start | busy` to hold any multiply/divide or HI/LO instruction in D, giving the pipeline MULT/DIV/MFHI/MFLO/MTHI/MTLO support without extra forwarding paths.

---
 rtl/md_unit_if.sv | 15 +
 rtl/md_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/md_unit_if.sv
// md_unit_if: request/result bundle between the E-stage issue logic and md_unit.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers and atomic commit.
// Optional MD_UNIT_MADD_EN enables ops 6/7 as MADD/MSUB; otherwise they are NOPs.
module md_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave md
);
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0]    MUL_CNT = CW'(MUL_CYCLES);
    localparam logic [CW-1:0]    DIV_CNT = CW'(DIV_CYCLES);
    localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_we_q, pend_we_d;

    logic [2*WIDTH-1:0] smul_s, umul_s;
    logic               div0_s, a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s, sdsor_s, udsor_s;
    logic [WIDTH-1:0]   mag_q_s, mag_r_s, sq_s, sr_s, uq_s, ur_s;

    // Results are computed at issue time; the busy period only models latency.
    assign smul_s  = {{WIDTH{md.a[WIDTH-1]}}, md.a} * {{WIDTH{md.b[WIDTH-1]}}, md.b};
    assign umul_s  = {{WIDTH{1'b0}}, md.a} * {{WIDTH{1'b0}}, md.b};
    assign div0_s  = (md.b == ZERO_W);
    assign a_neg_s = md.a[WIDTH-1];
    assign b_neg_s = md.b[WIDTH-1];
    assign a_mag_s = a_neg_s ? (~md.a + ONE_W) : md.a;
    assign b_mag_s = b_neg_s ? (~md.b + ONE_W) : md.b;
    assign sdsor_s = div0_s ? ONE_W : b_mag_s;
    assign udsor_s = div0_s ? ONE_W : md.b;
    assign mag_q_s = a_mag_s / sdsor_s;
    assign mag_r_s = a_mag_s % sdsor_s;
    // MIN / -1 falls out naturally: |MIN| negates back to MIN with a zero remainder.
    assign sq_s    = (a_neg_s ^ b_neg_s) ? (~mag_q_s + ONE_W) : mag_q_s;
    assign sr_s    = a_neg_s ? (~mag_r_s + ONE_W) : mag_r_s;
    assign uq_s    = md.a / udsor_s;
    assign ur_s    = md.a % udsor_s;

`ifdef MD_UNIT_MADD_EN
    logic [2*WIDTH-1:0] acc_add_s, acc_sub_s;
    assign acc_add_s = {hi_q, lo_q} + smul_s;
    assign acc_sub_s = {hi_q, lo_q} - smul_s;
`endif

    // Next-state logic: issue in IDLE, count down and commit in RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        case (state_q)
            IDLE: begin
                if (md.start) begin
                    case (md.op)
                        OP_MULT, OP_MULTU: begin
                            pend_hi_d = (md.op == OP_MULT) ? smul_s[2*WIDTH-1:WIDTH] : umul_s[2*WIDTH-1:WIDTH];
                            pend_lo_d = (md.op == OP_MULT) ? smul_s[WIDTH-1:0] : umul_s[WIDTH-1:0];
                            pend_we_d = 1'b1;
                            cnt_d     = MUL_CNT;
                            busy_d    = 1'b1;
                            state_d   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = (md.op == OP_DIV) ? sr_s : ur_s;
                            pend_lo_d = (md.op == OP_DIV) ? sq_s : uq_s;
                            pend_we_d = ~div0_s;
                            cnt_d     = DIV_CNT;
                            busy_d    = 1'b1;
                            state_d   = RUN;
                        end
                        OP_MTHI: hi_d = md.a;
                        OP_MTLO: lo_d = md.a;
`ifdef MD_UNIT_MADD_EN
                        OP_MADD, OP_MSUB: begin
                            pend_hi_d = (md.op == OP_MADD) ? acc_add_s[2*WIDTH-1:WIDTH] : acc_sub_s[2*WIDTH-1:WIDTH];
                            pend_lo_d = (md.op == OP_MADD) ? acc_add_s[WIDTH-1:0] : acc_sub_s[WIDTH-1:0];
                            pend_we_d = 1'b1;
                            cnt_d     = MUL_CNT;
                            busy_d    = 1'b1;
                            state_d   = RUN;
                        end
`endif
                        default: state_d = IDLE;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                    busy_d  = 1'b0;
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset that drops any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            busy_q    <= 1'b0;
            hi_q      <= ZERO_W;
            lo_q      <= ZERO_W;
            pend_hi_q <= ZERO_W;
            pend_lo_q <= ZERO_W;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    assign md.busy = busy_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule
